// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bus bundle between the fetch queue, the instruction ROM,
// the redirect source and the ID stage.
//   master : the fetch queue (drives ROM request, head entry, occupancy)
//   slave  : the environment (ROM data, redirect, ID ready)
// Signals:
//   rom_ce_o/rom_addr_o/rom_data_i          synchronous ROM, 1-cycle latency
//   redirect_i/redirect_pc_i                flush and restart fetch
//   deq_valid_o/deq_ready_i                 head handshake to ID
//   deq_pc_o/deq_inst_o/deq_pc31_o          head entry
//   count_o                                 FIFO occupancy
interface ifetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 3
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [ADDR_W-1:0] deq_pc_o;
  logic [INST_W-1:0] deq_inst_o;
  logic              deq_pc31_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output rom_ce_o, rom_addr_o, deq_valid_o, deq_pc_o, deq_inst_o,
           deq_pc31_o, count_o,
    input  rom_data_i, redirect_i, redirect_pc_i, deq_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, deq_valid_o, deq_pc_o, deq_inst_o,
           deq_pc31_o, count_o,
    output rom_data_i, redirect_i, redirect_pc_i, deq_ready_i
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end. Owns the fetch PC, issues reads
// to a 1-cycle-latency ROM and buffers returned {pc, inst} pairs in a
// DEPTH-entry FIFO drained by ID with valid/ready. A redirect flushes the
// FIFO, drops any returning word and restarts fetch at the (word-aligned)
// target.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ifetch_queue_if.master (ROM request/response, redirect, head, count)
// Configuration macro IFQ_BYPASS_EN: when defined, a ROM word arriving at an
// empty queue is presented on the head combinationally and, if accepted,
// is never written.
module ifetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {1'b1, {(ADDR_W-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic              w_empty, w_byp, w_valid, w_deq, w_deq_fifo, w_enq, w_issue;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INST_W-1:0] w_head_inst;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);

`ifdef IFQ_BYPASS_EN
  // A word returning in a redirect cycle is stale, so it is never bypassed.
  assign w_byp = w_empty && r_inflight && !rst && !bus.redirect_i;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid    = !rst && (!w_empty || w_byp);
  assign w_deq      = w_valid && bus.deq_ready_i;
  assign w_deq_fifo = w_deq && !w_byp;
  assign w_enq      = r_inflight && !rst && !bus.redirect_i && !(w_byp && bus.deq_ready_i);

  // Occupancy once this cycle's response lands and this cycle's dequeue
  // leaves; issuing only while it is below DEPTH keeps the FIFO from
  // ever overflowing without stalling the ROM.
  assign w_occ   = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_deq);
  assign w_issue = !rst && !bus.redirect_i && (w_occ < (CNT_W+1)'(DEPTH));

  assign w_head_pc   = w_byp ? r_inflight_pc : r_pc_mem[r_rd_ptr[PW-1:0]];
  assign w_head_inst = w_byp ? bus.rom_data_i : r_inst_mem[r_rd_ptr[PW-1:0]];

  assign bus.rom_ce_o    = w_issue;
  assign bus.rom_addr_o  = rst ? '0 : {1'b0, r_fetch_pc[ADDR_W-2:0]};
  assign bus.deq_valid_o = w_valid;
  assign bus.deq_pc_o    = w_valid ? w_head_pc : '0;
  assign bus.deq_inst_o  = w_valid ? w_head_inst : '0;
  assign bus.deq_pc31_o  = w_valid && w_head_pc[ADDR_W-1];
  assign bus.count_o     = rst ? '0 : w_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (bus.redirect_i) begin
      // Flush: returning word is dropped via w_enq, target is word-aligned.
      r_fetch_pc <= bus.redirect_pc_i & ~ADDR_W'(3);
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_enq)      r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      if (w_deq_fifo) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr[PW-1:0]]   <= r_inflight_pc;
      r_inst_mem[r_wr_ptr[PW-1:0]] <= bus.rom_data_i;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(32), .INST_W(32), .CNT_W(3)) ia ();
  ifetch_queue_if #(.ADDR_W(32), .INST_W(32), .CNT_W(3)) ib ();

  ifetch_queue #(.DEPTH(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_b (.clk(clk), .rst(rst), .bus(ib));

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] romf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ROM models: word for the issued address appears the next cycle.
  initial begin ia.rom_data_i = '0; ib.rom_data_i = '0; end
  always @(posedge clk) if (ia.rom_ce_o) ia.rom_data_i <= romf(ia.rom_addr_o);
  always @(posedge clk) if (ib.rom_ce_o) ib.rom_data_i <= romf(ib.rom_addr_o);

  // Scoreboards: every accepted head must be the next expected PC with its ROM word.
  logic [31:0] exp_a = 32'h8000_0000;
  logic [31:0] exp_b = 32'hFFFF_FFF8;
  int xfer_a = 0;
  int xfer_b = 0;

  always @(negedge clk) begin
    if (rst) exp_a = 32'h8000_0000;
    else begin
      if (ia.deq_valid_o && ia.deq_ready_i) begin
        chk("a_pc", ia.deq_pc_o, exp_a);
        chk("a_inst", ia.deq_inst_o, romf({1'b0, exp_a[30:0]}));
        chk("a_pc31", ia.deq_pc31_o, exp_a[31]);
        exp_a = exp_a + 32'd4;
        xfer_a++;
      end
      if (ia.redirect_i) exp_a = ia.redirect_pc_i & ~32'h3;
    end
  end

  always @(negedge clk) begin
    if (rst) exp_b = 32'hFFFF_FFF8;
    else if (ib.deq_valid_o && ib.deq_ready_i) begin
      chk("b_pc", ib.deq_pc_o, exp_b);
      chk("b_inst", ib.deq_inst_o, romf({1'b0, exp_b[30:0]}));
      chk("b_pc31", ib.deq_pc31_o, exp_b[31]);
      exp_b = exp_b + 32'd4;
      xfer_b++;
    end
  end

  initial begin
    int n;
    logic found;
    ia.deq_ready_i = 1'b0; ia.redirect_i = 1'b0; ia.redirect_pc_i = '0;
    ib.deq_ready_i = 1'b1; ib.redirect_i = 1'b0; ib.redirect_pc_i = '0;

    // Reset: three cycles, all outputs zero.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ce", ia.rom_ce_o, 0);
      chk("rst_addr", ia.rom_addr_o, 0);
      chk("rst_valid", ia.deq_valid_o, 0);
      chk("rst_count", ia.count_o, 0);
      chk("rst_pc", ia.deq_pc_o, 0);
      chk("rst_inst", ia.deq_inst_o, 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Stall fill: ID not ready from reset.
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ia.rom_ce_o) n++;
      if (c == 1) begin
        chk("c1_ce", ia.rom_ce_o, 1);
        chk("c1_addr", ia.rom_addr_o, 32'h0000_0000);
        chk("c1_valid", ia.deq_valid_o, 0);
      end
      if (c == 2) begin
        chk("c2_addr", ia.rom_addr_o, 32'h0000_0004);
        chk("c2_valid_byp", ia.deq_valid_o, BYP);
        if (BYP) chk("c2_byp_pc", ia.deq_pc_o, 32'h8000_0000);
      end
      if (c == 3) begin
        chk("c3_valid", ia.deq_valid_o, 1);
        chk("c3_pc", ia.deq_pc_o, 32'h8000_0000);
        chk("c3_pc31", ia.deq_pc31_o, 1);
        chk("c3_count", ia.count_o, 1);
      end
      if (c == 6) begin
        chk("c6_count", ia.count_o, 4);
        chk("c6_ce", ia.rom_ce_o, 0);
      end
    end
    chk("fill_issues", n, 4);
    chk("fill_count", ia.count_o, 4);
    chk("fill_inst", ia.deq_inst_o, romf(32'h0));

    // Release with full queue: same-cycle dequeue gives issue credit.
    @(posedge clk); #1 ia.deq_ready_i = 1'b1;
    @(negedge clk);
    chk("simul_ce", ia.rom_ce_o, 1);
    chk("simul_count", ia.count_o, 4);
    repeat (12) @(negedge clk);
    #1 chk("throughput", xfer_a, 13);

    // Redirect while 3 queued plus one word returning.
    @(posedge clk); #1
    ia.deq_ready_i = 1'b0; ia.redirect_i = 1'b1; ia.redirect_pc_i = 32'h0000_0100;
    @(negedge clk);
    chk("redir_ce", ia.rom_ce_o, 0);
    chk("redir_count_pre", ia.count_o, 3);
    @(posedge clk); #1 ia.redirect_i = 1'b0;
    @(negedge clk);
    chk("redir_count", ia.count_o, 0);
    chk("redir_valid", ia.deq_valid_o, 0);
    chk("redir_ce1", ia.rom_ce_o, 1);
    chk("redir_addr", ia.rom_addr_o, 32'h0000_0100);
    @(negedge clk);
    chk("redir_byp_valid", ia.deq_valid_o, BYP);
    @(negedge clk);
    chk("redir_head_valid", ia.deq_valid_o, 1);
    chk("redir_head_pc", ia.deq_pc_o, 32'h0000_0100);
    chk("redir_head_inst", ia.deq_inst_o, romf(32'h0000_0100));
    chk("redir_head_count", ia.count_o, 1);

    // Misaligned target, then back-to-back redirects.
    @(posedge clk); #1
    ia.deq_ready_i = 1'b1; ia.redirect_i = 1'b1; ia.redirect_pc_i = 32'h0000_0203;
    @(posedge clk); #1 ia.redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (ia.deq_valid_o) found = 1'b1;
    end
    chk("mis_found", found, 1);
    chk("mis_pc", ia.deq_pc_o, 32'h0000_0200);
    @(posedge clk); #1 ia.redirect_i = 1'b1; ia.redirect_pc_i = 32'h0000_0300;
    @(posedge clk); #1 ia.redirect_pc_i = 32'h0000_0407;
    @(posedge clk); #1 ia.redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (ia.deq_valid_o) found = 1'b1;
    end
    chk("b2b_found", found, 1);
    chk("b2b_pc", ia.deq_pc_o, 32'h0000_0404);

    // Random back-pressure with occasional redirects; scoreboards check order.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1
      ia.deq_ready_i   = 1'($urandom_range(0, 1));
      ia.redirect_i    = ($urandom_range(0, 63) == 0);
      ia.redirect_pc_i = $urandom;
      ib.deq_ready_i   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ia.count_o > 3'd4) chk("a_count_le4", ia.count_o, 4);
    end
    @(posedge clk); #1 ia.redirect_i = 1'b0;
    @(negedge clk); #1
    chk("a_progress", xfer_a > 2000, 1);
    chk("b_wrap_progress", xfer_b > 12, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
